// File: rtl/comb_bank_scheduler.sv
// comb_bank_scheduler
// Runs four feedback comb filters, one channel at a time, on a single shared
// single-port delay-line RAM. Each accepted sample walks RD/MAC/WR for every
// channel, then presents the averaged comb sum (or the raw sample when bypassed).
// After reset, or on a clear request in IDLE, the RAM is swept to zero.
module comb_bank_scheduler #(
    parameter int                 DELAY0     = 1557,
    parameter int                 DELAY1     = 1617,
    parameter int                 DELAY2     = 1491,
    parameter int                 DELAY3     = 1422,
    parameter logic signed [15:0] FEEDBACK   = 16'sd22937,
    parameter int                 ADDR_WIDTH = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] s_data,
    input  logic               bypass,
    input  logic               clear,
    output logic               m_valid,
    output logic signed [15:0] m_data,
    output logic               busy
);

    localparam int DEPTH = DELAY0 + DELAY1 + DELAY2 + DELAY3;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [2:0] S_CLR  = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_MAC  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    // Delay length of channel k (elaboration-time helper).
    function automatic int delay_of(input int k);
        case (k)
            0:       return DELAY0;
            1:       return DELAY1;
            2:       return DELAY2;
            default: return DELAY3;
        endcase
    endfunction

    // First RAM address of channel k: channels are packed back to back.
    function automatic int base_of(input int k);
        int b;
        b = 0;
        for (int j = 0; j < k; j++) begin
            b += delay_of(j);
        end
        return b;
    endfunction

    logic [2:0]               r_state;
    logic [1:0]               r_ch;
    logic [ADDR_WIDTH-1:0]    r_clr_addr;
    logic signed [15:0]       r_x;
    logic                     r_bypass;
    logic signed [17:0]       r_acc;
    logic signed [15:0]       r_wdata;
    logic signed [15:0]       r_m_data;
    logic [15:0]              r_rdata;
    logic [15:0]              r_mem [DEPTH];

    logic                     w_clr_start;
    logic [ADDR_WIDTH-1:0]    w_chan_addr [4];
    logic [ADDR_WIDTH-1:0]    w_addr;
    logic                     w_we;
    logic [15:0]              w_wdata;
    logic signed [15:0]       w_y;
    logic signed [31:0]       w_prod;
    logic signed [31:0]       w_sum;
    logic signed [15:0]       w_sat;
    logic signed [17:0]       w_acc_next;

    assign w_clr_start = (r_state == S_IDLE) && clear;
    assign s_ready     = (r_state == S_IDLE) && !clear;
    assign busy        = (r_state != S_IDLE);
    assign m_valid     = (r_state == S_OUT);
    assign m_data      = r_m_data;

    // Per-channel circular pointers and the resulting absolute RAM address.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(base_of(gi));
            localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(delay_of(gi) - 1);
            logic [ADDR_WIDTH-1:0] r_ptr;

            assign w_chan_addr[gi] = BASE + r_ptr;

            // Advance this channel's pointer after its write-back; zero on clear entry.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_ptr <= '0;
                end else if (w_clr_start) begin
                    r_ptr <= '0;
                end else if ((r_state == S_WR) && (r_ch == 2'(gi))) begin
                    r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
                end
            end
        end
    endgenerate

    // RAM port sharing: the clear sweep owns the port in CLR, the active channel otherwise.
    assign w_addr  = (r_state == S_CLR) ? r_clr_addr : w_chan_addr[r_ch];
    assign w_we    = (r_state == S_CLR) || (r_state == S_WR);
    assign w_wdata = (r_state == S_CLR) ? 16'd0 : r_wdata;

    // Comb arithmetic: feedback-scaled delayed sample plus input, saturated to 16 bits.
    assign w_y        = $signed(r_rdata);
    assign w_prod     = w_y * FEEDBACK;
    assign w_sum      = {{16{r_x[15]}}, r_x} + (w_prod >>> 15);
    assign w_acc_next = r_acc + {{2{w_y[15]}}, w_y};

    // Clamp the new delay-line word to the signed 16-bit range.
    always_comb begin
        w_sat = w_sum[15:0];
        if (w_sum > 32'sd32767) begin
            w_sat = 16'sh7FFF;
        end else if (w_sum < -32'sd32768) begin
            w_sat = 16'sh8000;
        end
    end

    // Single-port RAM: one write or one registered read per cycle, no reset on contents.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr] <= w_wdata;
        end else begin
            r_rdata <= r_mem[w_addr];
        end
    end

    // Sequencer: clear sweep, sample accept, per-channel RD/MAC/WR, then output strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_CLR;
            r_ch       <= 2'd0;
            r_clr_addr <= '0;
            r_x        <= '0;
            r_bypass   <= 1'b0;
            r_acc      <= '0;
            r_wdata    <= '0;
            r_m_data   <= '0;
        end else begin
            case (r_state)
                S_CLR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (clear) begin
                        r_state    <= S_CLR;
                        r_clr_addr <= '0;
                        r_acc      <= '0;
                    end else if (s_valid) begin
                        r_x      <= s_data;
                        r_bypass <= bypass;
                        r_ch     <= 2'd0;
                        r_acc    <= '0;
                        r_state  <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc   <= w_acc_next;
                    r_wdata <= w_sat;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (r_ch == 2'd3) begin
                        // Accumulator is final here; acc >>> 2 is the floor average.
                        r_m_data <= r_bypass ? r_x : r_acc[17:2];
                        r_state  <= S_OUT;
                    end else begin
                        r_ch    <= r_ch + 2'd1;
                        r_state <= S_RD;
                    end
                end
                S_OUT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comb_bank_scheduler.sv
// Testbench for comb_bank_scheduler: drives samples through the handshake and
// compares every output against a queue-based model of four comb filters.
module tb_comb_bank_scheduler;

    localparam int DEPTH = 6087;
    localparam int FB    = 22937;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_data = '0;
    logic               bypass = 1'b0;
    logic               clear = 1'b0;
    logic               m_valid;
    logic signed [15:0] m_data;
    logic               busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int sample_no = 0;
    int dly [4];
    int dl [4][$];
    int imp_out [1650];

    comb_bank_scheduler dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .bypass  (bypass),
        .clear   (clear),
        .m_valid (m_valid),
        .m_data  (m_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Delay lines as FIFOs: the oldest word is the one written DELAYk samples ago.
    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            dl[k].delete();
            for (int i = 0; i < dly[k]; i++) dl[k].push_back(0);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int model_step(input int x, input bit byp);
        int acc;
        int y;
        int p;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            y = dl[k].pop_front();
            acc += y;
            p = (y * FB) >>> 15;
            dl[k].push_back(sat16(x + p));
        end
        return byp ? x : (acc >>> 2);
    endfunction

    // Present one sample, wait for its strobe, check latency, data and strobe width.
    task automatic send(input int x, input bit byp, input bit chk_period, output int got);
        int n;
        int lat;
        int expv;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_wait", int'(s_ready), 1);
        if (chk_period) check("accept_period", cyc - last_acc, 14);
        last_acc = cyc;
        s_valid = 1'b1;
        s_data  = 16'(x);
        bypass  = byp;
        @(negedge clk);
        s_valid = 1'b0;
        bypass  = 1'b0;
        expv = model_step(x, byp);
        lat = 1;
        while (!m_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 13);
        check("m_data", int'(m_data), expv);
        got = int'(m_data);
        $display("sample %0d x=%0d byp=%0d m_data=%0d exp=%0d lat=%0d",
                 sample_no, x, byp, got, expv, lat);
        sample_no++;
        @(negedge clk);
        check("m_valid_width", int'(m_valid), 0);
    endtask

    task automatic wait_clr(input string tag, output int n);
        n = 0;
        while (!s_ready && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, DEPTH);
    endtask

    task automatic ram_zero(input string tag);
        int nz;
        nz = 0;
        for (int a = 0; a < DEPTH; a++) if (dut.r_mem[a] != 16'd0) nz++;
        check(tag, nz, 0);
    endtask

    initial begin
        int got;
        int n;
        int x;
        bit saw;
        dly[0] = 1557; dly[1] = 1617; dly[2] = 1491; dly[3] = 1422;
        model_reset();

        // Reset values while held in reset.
        #1;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_clr("clr_after_reset", n);
        ram_zero("ram_after_reset");

        // Impulse then zeros; accepts should be back to back every 14 cycles.
        for (int i = 0; i < 1650; i++) begin
            send((i == 0) ? 16384 : 0, 1'b0, i > 0, got);
            imp_out[i] = got;
        end
        check("imp_1", imp_out[1], 0);
        check("imp_1421", imp_out[1421], 0);
        check("imp_1422", imp_out[1422], 4096);
        check("imp_1491", imp_out[1491], 4096);
        check("imp_1557", imp_out[1557], 4096);
        check("imp_1617", imp_out[1617], 4096);

        // Random samples with random bypass.
        for (int i = 0; i < 200; i++) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            send(x, 1'($urandom_range(0, 1)), 1'b0, got);
        end

        // Bypassed ramp must come straight through.
        for (int i = 0; i < 20; i++) begin
            send(i * 1000 - 9000, 1'b1, 1'b0, got);
            check("bypass_ramp", got, i * 1000 - 9000);
        end

        // Full-scale DC long enough for every comb to wrap and saturate.
        for (int i = 0; i < 1650; i++) send(32767, 1'b0, 1'b0, got);
        check("dc_nonneg", int'(got >= 0), 1);

        // Clear in IDLE beats a simultaneous s_valid.
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        clear = 1'b1;
        s_valid = 1'b1;
        s_data = 16'sd1234;
        #1;
        check("ready_low_on_clear", int'(s_ready), 0);
        @(negedge clk);
        clear = 1'b0;
        s_valid = 1'b0;
        check("busy_after_clear", int'(busy), 1);
        wait_clr("clr_sweep_len", n);
        ram_zero("ram_after_clear");
        model_reset();
        for (int i = 0; i < 30; i++) begin
            send(0, 1'b0, 1'b0, got);
            check("zero_after_clear", got, 0);
        end

        // Reset in the middle of a sample: no strobe, sample discarded.
        send(12000, 1'b0, 1'b0, got);
        s_valid = 1'b1;
        s_data = 16'sd20000;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 1);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_s_ready", int'(s_ready), 0);
        check("midrst_m_data", int'(m_data), 0);
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m_valid) saw = 1'b1;
        end
        reset = 1'b1;
        n = 0;
        while (!s_ready && n < 8000) begin
            @(negedge clk);
            if (m_valid) saw = 1'b1;
            n++;
        end
        check("midrst_clr_len", n, DEPTH);
        check("midrst_no_strobe", int'(saw), 0);
        model_reset();
        for (int i = 0; i < 30; i++) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            send(x, 1'b0, 1'b0, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
